// File: rtl/pwrseq_pkg.sv
// Shared types and helpers for the power-sequencing input qualifiers.
package pwrseq_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'b00,
        QUAL_HIGH = 2'b01,
        ST_HIGH   = 2'b10,
        QUAL_LOW  = 2'b11
    } gf_state_t;

    // Qualification counter width, sized so the larger count fits without wrapping.
    function automatic int unsigned cnt_width(input int unsigned rise, input int unsigned fall);
        int unsigned m;
        m = (rise > fall) ? rise : fall;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/signal_sync.sv
// Multi-flop synchroniser for a single asynchronous input, reset to a chosen level.
module signal_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/glitch_filter.sv
// Synchronises a raw board signal and accepts level changes only after they
// have been stable for RISE_CNT / FALL_CNT clocks; emits one-cycle edge strobes.
module glitch_filter
    import pwrseq_pkg::*;
#(
    parameter int unsigned RISE_CNT    = 8,
    parameter int unsigned FALL_CNT    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_out,
    output logic rise_pls,
    output logic fall_pls,
    output logic busy
);

    if (RISE_CNT == 0 || FALL_CNT == 0 || SYNC_STAGES < 2) begin : g_param_check
        $fatal(1, "glitch_filter: RISE_CNT and FALL_CNT must be >= 1, SYNC_STAGES >= 2");
    end

    localparam int unsigned     CNT_W     = cnt_width(RISE_CNT, FALL_CNT);
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_CNT - 1);
    localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_CNT - 1);
    localparam gf_state_t        HOME      = RST_VAL ? ST_HIGH : ST_LOW;

    logic             s;
    gf_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sig_nxt, rise_nxt, fall_nxt;

    signal_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HOME;
            cnt      <= '0;
            sig_out  <= RST_VAL;
            rise_pls <= 1'b0;
            fall_pls <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sig_out  <= sig_nxt;
            rise_pls <= rise_nxt;
            fall_pls <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sig_nxt   = sig_out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ST_LOW: begin
                if (s) begin
                    if (RISE_CNT == 1) begin
                        state_nxt = ST_HIGH;
                        sig_nxt   = 1'b1;
                        rise_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = QUAL_HIGH;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            QUAL_HIGH: begin
                if (!s) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == RISE_LAST) begin
                    state_nxt = ST_HIGH;
                    sig_nxt   = 1'b1;
                    rise_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    if (FALL_CNT == 1) begin
                        state_nxt = ST_LOW;
                        sig_nxt   = 1'b0;
                        fall_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = QUAL_LOW;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            QUAL_LOW: begin
                if (s) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == FALL_LAST) begin
                    state_nxt = ST_LOW;
                    sig_nxt   = 1'b0;
                    fall_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = HOME;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == QUAL_HIGH) || (state == QUAL_LOW);

endmodule

// File: tb/tb_glitch_filter.sv
// Directed bench for glitch_filter across four parameter sets sharing one clock and reset.
module tb_glitch_filter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_a = 1'b0, in_b = 1'b0, in_c = 1'b0, in_d = 1'b1;
    logic out_a, rp_a, fp_a, bz_a;
    logic out_b, rp_b, fp_b, bz_b;
    logic out_c, rp_c, fp_c, bz_c;
    logic out_d, rp_d, fp_d, bz_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    glitch_filter u_a (
        .clk(clk), .rst_n(rst_n), .sig_in(in_a),
        .sig_out(out_a), .rise_pls(rp_a), .fall_pls(fp_a), .busy(bz_a)
    );

    glitch_filter #(.RISE_CNT(4), .FALL_CNT(12)) u_b (
        .clk(clk), .rst_n(rst_n), .sig_in(in_b),
        .sig_out(out_b), .rise_pls(rp_b), .fall_pls(fp_b), .busy(bz_b)
    );

    glitch_filter #(.RISE_CNT(1), .FALL_CNT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .sig_in(in_c),
        .sig_out(out_c), .rise_pls(rp_c), .fall_pls(fp_c), .busy(bz_c)
    );

    glitch_filter #(.RST_VAL(1'b1)) u_d (
        .clk(clk), .rst_n(rst_n), .sig_in(in_d),
        .sig_out(out_d), .rise_pls(rp_d), .fall_pls(fp_d), .busy(bz_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    task automatic chk_d_quiet(input int idx);
        chk("d_out", idx, 16'(out_d), 16'd1);
        chk("d_rp", idx, 16'(rp_d), 16'd0);
        chk("d_fp", idx, 16'(fp_d), 16'd0);
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_a_out", 0, 16'(out_a), 16'd0);
        chk("rst_a_busy", 0, 16'(bz_a), 16'd0);
        chk("rst_a_cnt", 0, 16'(u_a.cnt), 16'd0);
        chk("rst_b_out", 0, 16'(out_b), 16'd0);
        chk_d_quiet(0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rel_a_rp", 0, 16'(rp_a), 16'd0);
        chk("rel_a_fp", 0, 16'(fp_a), 16'd0);
        chk_d_quiet(1);

        // defaults: 0->1 step, rise on edge 10, busy edges 3..9
        in_a = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk("a_rise_out", i, 16'(out_a), 16'(i >= 10));
            chk("a_rise_rp", i, 16'(rp_a), 16'(i == 10));
            chk("a_rise_busy", i, 16'(bz_a), 16'(i >= 3 && i <= 9));
        end

        // defaults: 5-cycle low glitch filtered
        in_a = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 5) in_a = 1'b1;
            chk("a_gl_out", i, 16'(out_a), 16'd1);
            chk("a_gl_fp", i, 16'(fp_a), 16'd0);
            chk("a_gl_busy", i, 16'(bz_a), 16'(i >= 3 && i <= 7));
        end
        chk("a_gl_cnt", 0, 16'(u_a.cnt), 16'd0);

        // RISE 4 / FALL 12: rise latency 6
        in_b = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("b_rise_out", i, 16'(out_b), 16'(i >= 6));
            chk("b_rise_rp", i, 16'(rp_b), 16'(i == 6));
        end
        // 7-cycle low glitch filtered
        in_b = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 7) in_b = 1'b1;
            chk("b_gl_out", i, 16'(out_b), 16'd1);
            chk("b_gl_fp", i, 16'(fp_b), 16'd0);
        end
        // 14-cycle low passes, falls on edge 14
        in_b = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("b_fall_out", i, 16'(out_b), 16'(i < 14));
            chk("b_fall_fp", i, 16'(fp_b), 16'(i == 14));
        end

        // RISE 1 / FALL 1: 3-edge latency, never busy
        in_c = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("c_rise_out", i, 16'(out_c), 16'(i >= 3));
            chk("c_rise_rp", i, 16'(rp_c), 16'(i == 3));
            chk("c_rise_busy", i, 16'(bz_c), 16'd0);
        end
        in_c = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("c_fall_out", i, 16'(out_c), 16'(i < 3));
            chk("c_fall_fp", i, 16'(fp_c), 16'(i == 3));
        end
        // one-cycle high pulse passes as one-cycle high
        in_c = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) in_c = 1'b0;
            chk("c_pls_out", i, 16'(out_c), 16'(i == 3));
            chk("c_pls_rp", i, 16'(rp_c), 16'(i == 3));
            chk("c_pls_fp", i, 16'(fp_c), 16'(i == 4));
            chk("c_pls_busy", i, 16'(bz_c), 16'd0);
        end

        // defaults: bring a low, then reset mid-QUAL_HIGH at cnt 5
        in_a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("a_fall_fp", i, 16'(fp_a), 16'(i == 10));
        end
        chk("a_fall_out", 0, 16'(out_a), 16'd0);
        in_a = 1'b1;
        repeat (7) tick();
        chk("a_mid_cnt", 0, 16'(u_a.cnt), 16'd5);
        chk("a_mid_busy", 0, 16'(bz_a), 16'd1);
        rst_n = 1'b0;
        #2;
        chk("a_arst_out", 0, 16'(out_a), 16'd0);
        chk("a_arst_busy", 0, 16'(bz_a), 16'd0);
        chk("a_arst_rp", 0, 16'(rp_a), 16'd0);
        chk("a_arst_cnt", 0, 16'(u_a.cnt), 16'd0);
        chk_d_quiet(2);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk("a_rq_out", i, 16'(out_a), 16'(i >= 10));
            chk("a_rq_rp", i, 16'(rp_a), 16'(i == 10));
            chk("a_rq_busy", i, 16'(bz_a), 16'(i >= 3 && i <= 9));
            chk_d_quiet(10 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
